// File: rtl/acc_pkg.sv
// acc_pkg: shared ALU opcodes, datapath width defaults and execute FSM states
package acc_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 3;
    localparam logic [DEF_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [DEF_OP_W-1:0] ALU_SUB = 3'b001;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/acc_exec.sv
// acc_exec: accumulator execute sequencer driving an external combinational alu
// Optional compare request (flags only, accumulator kept) under ACC_EXEC_CMP_EN.
module acc_exec
    import acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [OP_W-1:0]   req_op_i,
    input  logic [DATA_W-1:0] req_operand_i,
    input  logic              req_load_i,
`ifdef ACC_EXEC_CMP_EN
    input  logic              req_cmp_i,
`endif
    output logic [DATA_W-1:0] alu_x_o,
    output logic [DATA_W-1:0] alu_y_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_r_i,
    input  logic              alu_fz_i,
    input  logic              alu_fc_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              fz_o,
    output logic              fc_o,
    output logic              done_o
);
    state_t state, nxt;
    logic   ld_q, cmp_q, cmp_in, accept;
`ifdef ACC_EXEC_CMP_EN
    assign cmp_in = req_cmp_i;
`else
    assign cmp_in = 1'b0;
`endif
    assign accept      = req_valid_i && req_ready_o;
    assign req_ready_o = state == IDLE;
    assign done_o      = state == DONE;
    assign alu_y_o     = acc_o;
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (req_valid_i ? EXEC : IDLE) : state == EXEC ? DONE : IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            alu_x_o  <= '0;
            alu_op_o <= '0;
            ld_q     <= 1'b0;
            cmp_q    <= 1'b0;
            acc_o    <= '0;
            fz_o     <= 1'b0;
            fc_o     <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                alu_x_o  <= req_operand_i;
                alu_op_o <= req_op_i;
                ld_q     <= req_load_i;
                cmp_q    <= cmp_in;
            end
            // load wins over compare; compare updates flags only
            if (state == EXEC) begin
                if (ld_q) begin
                    acc_o <= alu_x_o;
                    fz_o  <= alu_x_o == '0;
                end else begin
                    if (!cmp_q) acc_o <= alu_r_i;
                    fz_o <= alu_fz_i;
                    fc_o <= alu_fc_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_acc_exec.sv
// tb_acc_exec: directed self-checking bench for acc_exec with an inline alu model
module tb_acc_exec;
    import acc_pkg::*;
    logic       clk = 1'b0, rst = 1'b0, valid = 1'b0, ready, ld = 1'b0, cm = 1'b0;
    logic [2:0] op = 3'b000, alu_op;
    logic [7:0] opnd = 8'd0, alu_x, alu_y, alu_r, acc;
    logic       alu_fz, alu_fc, fz, fc, done;
    int         pass = 0, total = 0;

    always #5 clk = ~clk;

    always_comb begin
        logic [8:0] t;
        t = alu_op == ALU_SUB ? {1'b0, alu_y} - {1'b0, alu_x} :
            alu_op == ALU_ADD ? {1'b0, alu_y} + {1'b0, alu_x} : {1'b0, alu_y ^ alu_x};
        alu_r  = t[7:0];
        alu_fc = t[8];
        alu_fz = t[7:0] == 8'd0;
    end

    acc_exec dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
        .req_op_i(op), .req_operand_i(opnd), .req_load_i(ld),
`ifdef ACC_EXEC_CMP_EN
        .req_cmp_i(cm),
`endif
        .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_op_o(alu_op),
        .alu_r_i(alu_r), .alu_fz_i(alu_fz), .alu_fc_i(alu_fc),
        .acc_o(acc), .fz_o(fz), .fc_o(fc), .done_o(done)
    );

    task automatic issue(input logic [2:0] o, input logic [7:0] v, input logic l, input logic c);
        int n = 0;
        @(negedge clk);
        valid = 1'b1; op = o; opnd = v; ld = l; cm = c;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ready !== 1'b1) $display("FAIL accept_wait: ready=%b required 1", ready);
        else pass++;
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (ready !== 1'b0 || done !== 1'b0) $display("FAIL exec_phase: ready=%b done=%b required 0 0", ready, done);
        else pass++;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || done !== 1'b1) $display("FAIL done_phase: ready=%b done=%b required 0 1", ready, done);
        else pass++;
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0) $display("FAIL idle_again: ready=%b done=%b required 1 0", ready, done);
        else pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({acc, fz, fc, ready, done, alu_x, alu_op} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0})
            $display("FAIL reset: acc=%0d fz=%b fc=%b ready=%b done=%b x=%0d op=%0d required 0 0 0 1 0 0 0",
                     acc, fz, fc, ready, done, alu_x, alu_op);
        else pass++;
    endtask

    task automatic test_load_sub();
        issue(ALU_ADD, 8'd5, 1'b1, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd5, 1'b0, 1'b0}) $display("FAIL load5: acc=%0d fz=%b fc=%b required 5 0 0", acc, fz, fc);
        else pass++;
        issue(ALU_SUB, 8'd2, 1'b0, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd3, 1'b0, 1'b0}) $display("FAIL sub2: acc=%0d fz=%b fc=%b required 3 0 0", acc, fz, fc);
        else pass++;
        total++;
        if (alu_y !== 8'd3) $display("FAIL alu_y: got %0d required 3", alu_y);
        else pass++;
    endtask

    task automatic test_sub_flags();
        issue(ALU_SUB, 8'd3, 1'b0, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd0, 1'b1, 1'b0}) $display("FAIL sub_zero: acc=%0d fz=%b fc=%b required 0 1 0", acc, fz, fc);
        else pass++;
        issue(ALU_ADD, 8'd1, 1'b1, 1'b0);
        issue(ALU_SUB, 8'd4, 1'b0, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd253, 1'b0, 1'b1}) $display("FAIL sub_borrow: acc=%0d fz=%b fc=%b required 253 0 1", acc, fz, fc);
        else pass++;
    endtask

    task automatic test_add_carry();
        issue(ALU_ADD, 8'd255, 1'b1, 1'b0);
        issue(ALU_ADD, 8'd1, 1'b0, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd0, 1'b1, 1'b1}) $display("FAIL add_carry: acc=%0d fz=%b fc=%b required 0 1 1", acc, fz, fc);
        else pass++;
        issue(ALU_SUB, 8'd0, 1'b1, 1'b0);
        total++;
        if ({acc, fz, fc} !== {8'd0, 1'b1, 1'b1}) $display("FAIL load0: acc=%0d fz=%b fc=%b required 0 1 1", acc, fz, fc);
        else pass++;
        total++;
        if (alu_x !== 8'd0 || alu_op !== ALU_SUB) $display("FAIL alu_hold: x=%0d op=%0d required 0 1", alu_x, alu_op);
        else pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_acc = 8'd0;
        @(negedge clk);
        valid = 1'b1; op = ALU_ADD; opnd = 8'd1; ld = 1'b0; cm = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 9) valid = 1'b0;
            if (i % 3 == 2) exp_acc++;
            total++;
            if (done !== (i % 3 == 2) || ready !== (i % 3 == 0) || acc !== exp_acc)
                $display("FAIL b2b_%0d: done=%b ready=%b acc=%0d required %b %b %0d",
                         i, done, ready, acc, i % 3 == 2, i % 3 == 0, exp_acc);
            else pass++;
        end
        @(negedge clk);
        total++;
        if (acc !== 8'd3 || ready !== 1'b1) $display("FAIL b2b_end: acc=%0d ready=%b required 3 1", acc, ready);
        else pass++;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (done !== 1'b0 || acc !== 8'd0 || ready !== 1'b1 || fc !== 1'b0)
            $display("FAIL reset_exec: done=%b acc=%0d ready=%b fc=%b required 0 0 1 0", done, acc, ready, fc);
        else pass++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || acc !== 8'd0) $display("FAIL reset_after: done=%b acc=%0d required 0 0", done, acc);
        else pass++;
    endtask

`ifdef ACC_EXEC_CMP_EN
    task automatic test_cmp();
        issue(ALU_ADD, 8'd7, 1'b1, 1'b0);
        issue(ALU_SUB, 8'd9, 1'b0, 1'b1);
        total++;
        if ({acc, fz, fc} !== {8'd7, 1'b0, 1'b1}) $display("FAIL cmp: acc=%0d fz=%b fc=%b required 7 0 1", acc, fz, fc);
        else pass++;
        issue(ALU_ADD, 8'd4, 1'b1, 1'b1);
        total++;
        if ({acc, fz, fc} !== {8'd4, 1'b0, 1'b1}) $display("FAIL load_over_cmp: acc=%0d fz=%b fc=%b required 4 0 1", acc, fz, fc);
        else pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_sub();
        test_sub_flags();
        test_add_carry();
        test_back_to_back();
`ifdef ACC_EXEC_CMP_EN
        test_cmp();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
